// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents: fetch FSM state enum, reset PC default, instruction/PC widths,
// the IF/ID payload struct and a word-alignment helper.
package if_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc4;
  } ifid_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n  - clock, async active-low reset (payload cleared to 0)
//   i_flush     - clear valid (squash); wins over everything else
//   i_hold      - keep the whole payload unchanged
//   i_load      - capture i_d; when neither held nor loaded, valid drops (bubble)
//   i_d / o_q   - payload in / out
module ifid_reg
  import if_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_flush,
  input  logic  i_hold,
  input  logic  i_load,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q.valid <= 1'b0;
    end else if (!i_hold) begin
      if (i_load) r_q <= i_d;
      else        r_q.valid <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, instruction-memory request handshake,
// pending-redirect tracking, one-entry skid buffer and the IF/ID register.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   i_stall_id                 - ID cannot take a new instruction
//   i_redirect_valid/_pc       - taken branch/jump target from ID
//   o_imem_req/o_imem_addr     - fetch request and address
//   i_imem_ready/i_imem_rdata  - fetch response
//   o_ifid_*                   - IF/ID register contents
//
// state | meaning
// FETCH | request outstanding at r_pc; response goes to IF/ID or the buffer
// HOLD  | buffer full while ID stalls; no request issued
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_stall_id,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ready,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_ifid_valid,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic [15:0]        o_ifid_imm16,
  output logic [ADDR_W-1:0]  o_ifid_pc,
  output logic [ADDR_W-1:0]  o_ifid_pc4
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_pc;
  logic               r_pend_valid;
  logic [ADDR_W-1:0]  r_pend_pc;
  logic               r_buf_valid;
  logic [INSTR_W-1:0] r_buf_instr;
  logic [ADDR_W-1:0]  r_buf_pc;

  ifid_t w_ifid_q;
  ifid_t w_ifid_d;
  logic  w_ifid_load;
  logic  w_req;
  logic  w_xfer;
  logic  w_accept;
  logic  [ADDR_W-1:0] w_redir_pc;

  // Request is gated by rst_n so it drops the moment reset asserts.
  assign w_req      = rst_n && (r_state == FETCH);
  assign w_xfer     = w_req && i_imem_ready;
  assign w_accept   = !w_ifid_q.valid || !i_stall_id;
  assign w_redir_pc = word_align(i_redirect_pc);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        if (w_xfer && !i_redirect_valid && !r_pend_valid && !w_accept)
          w_state_nxt = HOLD;
      end
      HOLD: begin
        if (i_redirect_valid || w_accept)
          w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // Output logic: request and what (if anything) IF/ID captures this cycle
  always_comb begin
    o_imem_req  = w_req;
    w_ifid_load = 1'b0;
    w_ifid_d    = '{valid: 1'b1, instr: i_imem_rdata, pc: r_pc, pc4: r_pc + 32'd4};
    case (r_state)
      FETCH: begin
        // Data returning for a squashed address (redirect now or pending) is dropped.
        w_ifid_load = w_xfer && !i_redirect_valid && !r_pend_valid && w_accept;
      end
      HOLD: begin
        w_ifid_load = r_buf_valid && w_accept && !i_redirect_valid;
        w_ifid_d    = '{valid: 1'b1, instr: r_buf_instr, pc: r_buf_pc,
                        pc4: r_buf_pc + 32'd4};
      end
      default: w_ifid_load = 1'b0;
    endcase
  end

  // PC, pending redirect and skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_buf_valid  <= 1'b0;
      r_buf_instr  <= '0;
      r_buf_pc     <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_xfer) begin
            if (i_redirect_valid) begin
              r_pc         <= w_redir_pc;
              r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
              r_pc         <= r_pend_pc;
              r_pend_valid <= 1'b0;
            end else begin
              r_pc <= r_pc + 32'd4;
              if (!w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_instr <= i_imem_rdata;
                r_buf_pc    <= r_pc;
              end
            end
          end else if (i_redirect_valid) begin
            // Address must stay put until the in-flight response returns.
            r_pend_valid <= 1'b1;
            r_pend_pc    <= w_redir_pc;
          end
        end
        HOLD: begin
          if (i_redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_buf_valid <= 1'b0;
          end else if (w_accept) begin
            r_buf_valid <= 1'b0;
          end
        end
        default: r_buf_valid <= 1'b0;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_redirect_valid),
    .i_hold  (!w_accept),
    .i_load  (w_ifid_load),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign o_imem_addr  = r_pc;
  assign o_ifid_valid = w_ifid_q.valid;
  assign o_ifid_instr = w_ifid_q.instr;
  assign o_ifid_imm16 = w_ifid_q.instr[15:0];
  assign o_ifid_pc    = w_ifid_q.pc;
  assign o_ifid_pc4   = w_ifid_q.pc4;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_id;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [15:0] ifid_imm16;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall_id       (stall_id),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_ready     (imem_ready),
    .i_imem_rdata     (imem_rdata),
    .o_ifid_valid     (ifid_valid),
    .o_ifid_instr     (ifid_instr),
    .o_ifid_imm16     (ifid_imm16),
    .o_ifid_pc        (ifid_pc),
    .o_ifid_pc4       (ifid_pc4)
  );

  // Memory content: upper half 0x2008, lower half addr[15:0] ^ 0xCFFF
  // (0x3000 -> 0x2008FFFF, 0x3004 -> 0x2008FFFB, 0x3400 -> 0x2008FBFF).
  assign imem_rdata = {16'h2008, imem_addr[15:0] ^ 16'hCFFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_id = 1'b0; redir_v = 1'b0; redir_pc = '0; imem_ready = 1'b0;
    #2;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_pc",    ifid_pc,             32'd0);
    chk("rst_instr", ifid_instr,          32'd0);
    chk("rst_pc4",   ifid_pc4,            32'd0);
    tick(); tick();

    // Zero-wait memory
    imem_ready = 1'b1; rst_n = 1'b1; #1;
    chk("zw_req0",  {31'd0, imem_req}, 32'd1);
    chk("zw_addr0", imem_addr,         32'h3000);
    tick();
    chk("zw_valid0", {31'd0, ifid_valid}, 32'd1);
    chk("zw_pc0",    ifid_pc,             32'h3000);
    chk("zw_instr0", ifid_instr,          32'h2008FFFF);
    chk("zw_imm0",   {16'd0, ifid_imm16}, 32'h0000FFFF);
    chk("zw_pc4_0",  ifid_pc4,            32'h3004);
    chk("zw_addr1",  imem_addr,           32'h3004);
    tick();
    chk("zw_pc1",    ifid_pc,             32'h3004);
    chk("zw_imm1",   {16'd0, ifid_imm16}, 32'h0000FFFB);
    tick();
    chk("zw_pc2",    ifid_pc,             32'h3008);
    chk("zw_valid2", {31'd0, ifid_valid}, 32'd1);

    // Two wait states per fetch (async reset checked mid-run as well)
    rst_n = 1'b0; #1;
    chk("ar_req",   {31'd0, imem_req},   32'd0);
    chk("ar_valid", {31'd0, ifid_valid}, 32'd0);
    imem_ready = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    chk("ws_addr_c0", imem_addr, 32'h3000);
    tick();
    chk("ws_valid_c1", {31'd0, ifid_valid}, 32'd0);
    chk("ws_addr_c1",  imem_addr,           32'h3000);
    tick();
    chk("ws_addr_c2", imem_addr, 32'h3000);
    imem_ready = 1'b1;
    tick();
    chk("ws_valid_d0", {31'd0, ifid_valid}, 32'd1);
    chk("ws_pc_d0",    ifid_pc,             32'h3000);
    chk("ws_addr_d0",  imem_addr,           32'h3004);
    imem_ready = 1'b0;
    tick();
    chk("ws_bubble1", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("ws_bubble2", {31'd0, ifid_valid}, 32'd0);
    chk("ws_addr_w",  imem_addr,           32'h3004);
    imem_ready = 1'b1;
    tick();
    chk("ws_valid_d1", {31'd0, ifid_valid}, 32'd1);
    chk("ws_pc_d1",    ifid_pc,             32'h3004);

    // Stall while a fetch completes
    rst_n = 1'b0; tick();
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    chk("st_pc_pre", ifid_pc, 32'h3000);
    stall_id = 1'b1; #1;
    chk("st_addr_pre", imem_addr, 32'h3004);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_hold_req",   {31'd0, imem_req},   32'd0);
      chk("st_hold_pc",    ifid_pc,             32'h3000);
      chk("st_hold_valid", {31'd0, ifid_valid}, 32'd1);
    end
    stall_id = 1'b0;
    tick();
    chk("st_buf_valid", {31'd0, ifid_valid}, 32'd1);
    chk("st_buf_pc",    ifid_pc,             32'h3004);
    chk("st_buf_instr", ifid_instr,          32'h2008FFFB);
    chk("st_resume_req",  {31'd0, imem_req}, 32'd1);
    chk("st_resume_addr", imem_addr,         32'h3008);
    tick();
    chk("st_next_pc", ifid_pc, 32'h3008);
    tick();
    chk("st_next_pc2", ifid_pc, 32'h300C);

    // Redirect during a wait state at 0x3010 (low bits of target ignored)
    imem_ready = 1'b0; #1;
    chk("rw_addr_pre", imem_addr, 32'h3010);
    redir_v = 1'b1; redir_pc = 32'h0000_3403;
    tick();
    redir_v = 1'b0; redir_pc = '0;
    chk("rw_flush",  {31'd0, ifid_valid}, 32'd0);
    chk("rw_addr_a", imem_addr,           32'h3010);
    tick();
    chk("rw_addr_b",  imem_addr,           32'h3010);
    chk("rw_valid_b", {31'd0, ifid_valid}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("rw_discard", {31'd0, ifid_valid}, 32'd0);
    chk("rw_addr_new", imem_addr,          32'h3400);
    tick();
    chk("rw_valid_new", {31'd0, ifid_valid}, 32'd1);
    chk("rw_pc_new",    ifid_pc,             32'h3400);
    chk("rw_instr_new", ifid_instr,          32'h2008FBFF);

    // Redirect in HOLD with stall asserted
    stall_id = 1'b1;
    tick();
    chk("rh_req_hold", {31'd0, imem_req}, 32'd0);
    chk("rh_pc_hold",  ifid_pc,           32'h3400);
    redir_v = 1'b1; redir_pc = 32'h0000_3100;
    tick();
    redir_v = 1'b0; redir_pc = '0;
    chk("rh_flush", {31'd0, ifid_valid}, 32'd0);
    chk("rh_req",   {31'd0, imem_req},   32'd1);
    chk("rh_addr",  imem_addr,           32'h3100);
    stall_id = 1'b0;
    tick();
    chk("rh_valid_new", {31'd0, ifid_valid}, 32'd1);
    chk("rh_pc_new",    ifid_pc,             32'h3100);

    // Reset pulsed mid-wait; late ready during reset must not be delivered
    imem_ready = 1'b0;
    tick();
    chk("rm_addr_wait", imem_addr, 32'h3104);
    rst_n = 1'b0; #1;
    chk("rm_req",   {31'd0, imem_req},   32'd0);
    chk("rm_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rm_pc",    ifid_pc,             32'd0);
    imem_ready = 1'b1;
    tick();
    chk("rm_late_ready", {31'd0, ifid_valid}, 32'd0);
    rst_n = 1'b1; imem_ready = 1'b0; #1;
    chk("rm_req_rel",  {31'd0, imem_req}, 32'd1);
    chk("rm_addr_rel", imem_addr,         32'h3000);
    tick();
    chk("rm_valid_rel", {31'd0, ifid_valid}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("rm_valid_d", {31'd0, ifid_valid}, 32'd1);
    chk("rm_pc_d",    ifid_pc,             32'h3000);

    // Redirect coinciding with a transfer, then PC wrap
    redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir_v = 1'b0; redir_pc = '0;
    chk("wr_flush", {31'd0, ifid_valid}, 32'd0);
    chk("wr_addr",  imem_addr,           32'hFFFF_FFFC);
    tick();
    chk("wr_valid", {31'd0, ifid_valid}, 32'd1);
    chk("wr_pc",    ifid_pc,             32'hFFFF_FFFC);
    chk("wr_pc4",   ifid_pc4,            32'h0000_0000);
    chk("wr_instr", ifid_instr,          32'h2008_3003);
    chk("wr_addr0", imem_addr,           32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage of the 5-stage MIPS core: owns the PC, drives the instruction-memory request handshake and holds the IF/ID pipeline register.
- The IF/ID register supplies ifid_imm16 directly to the ID-stage immediate extender and ifid_instr to the controller that produces the extension opcode.
- Accepts a single redirect (branch/jump target) from ID.
- No branch delay slot: a redirect squashes every younger fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stall_id  in  1  ID cannot accept a new instruction; IF/ID must hold.
- redirect_valid  in  1  ID resolved a taken branch/jump this cycle.
- redirect_pc  in  32  target PC; word-aligned, low 2 bits ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and no ready has been received.
- imem_ready  in  1  read data valid; may be high in the same cycle as imem_req (zero-wait).
- imem_rdata  in  32  instruction word; valid only when imem_ready=1.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  instruction word.
- ifid_imm16  out  16  equals ifid_instr[15:0]; feeds the immediate extender.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc4  out  32  ifid_pc + 4; used for link and branch base.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc = RESET_PC, state = FETCH.
  - ifid_valid = 0; ifid_instr, ifid_pc and ifid_pc4 = 0.
  - pend_valid = 0, buf_valid = 0.
  - imem_req is forced to 0 while rst_n=0.
  - After reset releases, imem_req = 1 in the first cycle.
- Accept condition: accept = !ifid_valid || !stall_id.
- FETCH state:
  - imem_req = 1, imem_addr = pc.
  - A transfer occurs on a cycle with imem_req & imem_ready.
  - Transfer with redirect_valid, or with pend_valid set: discard the data. pc <= redirect_pc (or pend_pc), clear pend_valid, stay in FETCH.
  - Transfer with no redirect and accept: IF/ID <= {valid=1, instr=rdata, pc, pc+4}; pc <= pc+4; stay in FETCH. This gives one instruction per cycle with a zero-wait memory.
  - Transfer with no redirect and !accept: buf <= {rdata, pc}, buf_valid=1; pc <= pc+4; go to HOLD.
  - redirect_valid with no transfer: pend_valid <= 1, pend_pc <= redirect_pc. imem_addr does not change until the in-flight ready arrives.
  - A second redirect while pend_valid=1 overwrites pend_pc (latest wins).
- HOLD state:
  - imem_req = 0.
  - If accept: IF/ID <= buf, buf_valid <= 0, go to FETCH.
  - If redirect_valid: drop buf, pc <= redirect_pc, go to FETCH. Redirect has priority over accept.
- IF/ID update rules:
  - redirect_valid clears ifid_valid to 0 (flush), overriding stall_id.
  - If stall_id=1, ifid_valid=1 and there is no redirect, all ifid_* hold their values.
  - If accept holds and no instruction is delivered this cycle, ifid_valid <= 0 (bubble).
- PC increment wraps modulo 2^32 with no trap. 32'hFFFF_FFFC + 4 = 0.
- Latency: ready at edge N gives ifid_valid=1 after edge N (one register stage).

Decomposition:
- Package if_pkg holds:
  - fetch_state_t enum {FETCH, HOLD}
  - RESET_PC_DEFAULT
  - INSTR_W = 32
  - a struct for the IF/ID payload {valid, instr, pc, pc4}
- Sub-module ifid_reg is a natural split: the payload register with load, hold and flush controls, async active-low reset.
- The FSM, PC, pending-redirect and skid buffer logic stay in if_fetch_unit.

Test Plan:
- Reset, zero-wait memory (imem_ready tied 1): after reset, ifid_pc sequence is 0x3000, 0x3004, 0x3008 on consecutive cycles. ifid_imm16 = low half of each word, e.g. rdata 0x2008FFFF gives imm16 0xFFFF.
- Two wait states per fetch: imem_addr holds 0x3000 for 3 cycles. One instruction is delivered every 3 cycles and ifid_valid=0 in between.
- stall_id=1 for 4 cycles while a fetch completes: the FSM enters HOLD and imem_req=0. IF/ID is unchanged. After release, the buffered word (pc 0x3004) appears and fetching resumes at 0x3008. No instruction is lost or duplicated.
- Redirect to 0x3400 during a wait state at addr 0x3010: imem_addr stays 0x3010 until ready, that data is discarded, the next request goes to 0x3400, and ifid_valid=0 in the cycle after the redirect.
- Redirect in HOLD, with stall_id=1 and redirect 0x3100 in the same cycle: the buffer is dropped, ifid_valid=0 and the next fetch address is 0x3100.
- rst_n pulsed low mid-wait: outputs immediately go to their reset values (imem_req=0, ifid_valid=0). After release, fetch restarts at 0x3000 and the late imem_ready from the old request is not delivered.
